// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared types and constants for the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

   localparam int unsigned DEF_ADDR_W = 32;
   localparam int unsigned DEF_INS_W  = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_perf_counters.sv
// ============================================================================
// fetch_perf_counters : saturating fetch/stall/flush event counters
// Present only when FETCH_PERF_CNT_EN is defined.  Rev 1.0
// ============================================================================
`default_nettype none

`ifdef FETCH_PERF_CNT_EN
module fetch_perf_counters (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_evt_i,
   input  logic        stall_evt_i,
   input  logic        flush_evt_i,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   logic [2:0]        evt;
   logic [2:0][31:0]  cnt_q;
   logic [2:0][31:0]  cnt_d;

   assign evt = {flush_evt_i, stall_evt_i, fetch_evt_i};

   // Counters stick at all-ones rather than wrapping back to zero.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (evt[i] && !(&cnt_q[i])) begin
            cnt_d[i] = cnt_q[i] + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign fetch_cnt_o = cnt_q[0];
   assign stall_cnt_o = cnt_q[1];
   assign flush_cnt_o = cnt_q[2];

endmodule
`endif

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : PC register and IF/ID pipeline register (BOOT/RUN/HALTED)
// Optional perf counters via FETCH_PERF_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module fetch_stage
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned INS_W    = DEF_INS_W,
   parameter int unsigned PC_STEP  = 4,
   parameter int unsigned RESET_PC = 0,
   parameter int unsigned MEM_LAST = 95
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic              halt_i,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic [INS_W-1:0]  imem_instr_i,
   output logic              id_valid_o,
   output logic [INS_W-1:0]  id_instr_o,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [ADDR_W-1:0] id_pc_plus_o,
   output logic              halted_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt_o,
   output logic [31:0]       stall_cnt_o,
   output logic [31:0]       flush_cnt_o
`endif
);

   localparam logic [ADDR_W-1:0] C_PC_STEP  = ADDR_W'(PC_STEP);
   localparam logic [ADDR_W-1:0] C_RESET_PC = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] C_MEM_LAST = ADDR_W'(MEM_LAST);
   localparam logic [INS_W-1:0]  C_NOP      = INS_W'(NOP_INSTR);

   fetch_state_t      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              id_valid_q, id_valid_d;
   logic [INS_W-1:0]  id_instr_q, id_instr_d;
   logic [ADDR_W-1:0] id_pc_q, id_pc_d;
   logic [ADDR_W-1:0] id_pc_plus_q, id_pc_plus_d;
   logic              halted_q, halted_d;
   logic              go_halt;

   // Running off the end of instruction memory is treated exactly like halt_i.
   assign go_halt = halt_i || (pc_q > C_MEM_LAST);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      id_valid_d   = id_valid_q;
      id_instr_d   = id_instr_q;
      id_pc_d      = id_pc_q;
      id_pc_plus_d = id_pc_plus_q;
      halted_d     = halted_q;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (go_halt) begin
               state_d    = HALTED;
               id_valid_d = 1'b0;
               id_instr_d = C_NOP;
               halted_d   = 1'b1;
            end else if (redirect_i) begin
               pc_d       = redirect_pc_i;
               id_valid_d = 1'b0;
               id_instr_d = C_NOP;
            end else if (!stall_i) begin
               id_instr_d   = imem_instr_i;
               id_pc_d      = pc_q;
               id_pc_plus_d = pc_q + C_PC_STEP;
               id_valid_d   = 1'b1;
               pc_d         = pc_q + C_PC_STEP;
            end
         end
         default: begin
            id_valid_d = 1'b0;
            id_instr_d = C_NOP;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= BOOT;
         pc_q         <= C_RESET_PC;
         id_valid_q   <= 1'b0;
         id_instr_q   <= C_NOP;
         id_pc_q      <= '0;
         id_pc_plus_q <= '0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         id_valid_q   <= id_valid_d;
         id_instr_q   <= id_instr_d;
         id_pc_q      <= id_pc_d;
         id_pc_plus_q <= id_pc_plus_d;
         halted_q     <= halted_d;
      end
   end

   assign imem_addr_o  = pc_q;
   assign id_valid_o   = id_valid_q;
   assign id_instr_o   = id_instr_q;
   assign id_pc_o      = id_pc_q;
   assign id_pc_plus_o = id_pc_plus_q;
   assign halted_o     = halted_q;

`ifdef FETCH_PERF_CNT_EN
   logic in_run;
   assign in_run = (state_q == RUN) && !go_halt;

   fetch_perf_counters u_perf (
      .clk         (clk),
      .reset       (reset),
      .fetch_evt_i (in_run && !redirect_i && !stall_i),
      .stall_evt_i (in_run && !redirect_i && stall_i),
      .flush_evt_i (in_run && redirect_i),
      .fetch_cnt_o (fetch_cnt_o),
      .stall_cnt_o (stall_cnt_o),
      .flush_cnt_o (flush_cnt_o)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// tb_fetch_stage : scoreboard bench for fetch_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        halt_i;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_instr_i;
   logic        id_valid_o;
   logic [31:0] id_instr_o;
   logic [31:0] id_pc_o;
   logic [31:0] id_pc_plus_o;
   logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] stall_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] plus;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   fetch_stage dut (
      .clk           (clk),
      .reset         (reset),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .halt_i        (halt_i),
      .imem_addr_o   (imem_addr_o),
      .imem_instr_i  (imem_instr_i),
      .id_valid_o    (id_valid_o),
      .id_instr_o    (id_instr_o),
      .id_pc_o       (id_pc_o),
      .id_pc_plus_o  (id_pc_plus_o),
      .halted_o      (halted_o)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt_o   (fetch_cnt_o),
      .stall_cnt_o   (stall_cnt_o),
      .flush_cnt_o   (flush_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   // Instruction memory: each word is tagged with its own address.
   assign imem_instr_i = 32'h1000_0000 | imem_addr_o;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] plus);
      exp_t e;
      e.instr = instr;
      e.pc    = pc;
      e.plus  = plus;
      exp_q.push_back(e);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_bubble(input string name, input logic [31:0] addr, input logic halted);
      chk({name, "_valid"}, {31'd0, id_valid_o}, 32'd0);
      chk({name, "_instr"}, id_instr_o, 32'h0000_0013);
      chk({name, "_addr"}, imem_addr_o, addr);
      chk({name, "_halted"}, {31'd0, halted_o}, {31'd0, halted});
   endtask

   // Monitor: every cycle the IF/ID register shows a valid instruction it must match the next expectation.
   always @(negedge clk) begin
      if (!done && id_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got valid instr %h pc %h with no expectation", id_instr_o, id_pc_o);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_instr", id_instr_o, e.instr);
            chk("sb_pc", id_pc_o, e.pc);
            chk("sb_pc_plus", id_pc_plus_o, e.plus);
         end
      end
   end

   initial begin
      reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0; halt_i = 1'b0;
      cyc(); cyc();
      chk_bubble("reset", 32'd0, 1'b0);
      chk("reset_id_pc", id_pc_o, 32'd0);
      chk("reset_id_pc_plus", id_pc_plus_o, 32'd0);

      reset = 1'b0;
      cyc();
      chk_bubble("boot", 32'd0, 1'b0);

      push(32'h1000_0000, 32'd0, 32'd4); cyc();
      push(32'h1000_0004, 32'd4, 32'd8); cyc();
      chk("seq_addr", imem_addr_o, 32'd8);

      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(32'h1000_0004, 32'd4, 32'd8); cyc();
         chk("stall_addr", imem_addr_o, 32'd8);
      end
      stall_i = 1'b0;

      push(32'h1000_0008, 32'd8,  32'd12); cyc();
      push(32'h1000_000C, 32'd12, 32'd16); cyc();
      push(32'h1000_0010, 32'd16, 32'd20); cyc();
      push(32'h1000_0014, 32'd20, 32'd24); cyc();
      push(32'h1000_0018, 32'd24, 32'd28); cyc();
      chk("pre_redirect_addr", imem_addr_o, 32'd28);

      // Redirect beats a simultaneous stall.
      redirect_i = 1'b1; redirect_pc_i = 32'd30; stall_i = 1'b1;
      cyc();
      redirect_i = 1'b0; stall_i = 1'b0;
      chk_bubble("redirect", 32'd30, 1'b0);
      chk("redirect_pc_hold", id_pc_o, 32'd24);
      push(32'h1000_001E, 32'd30, 32'd34); cyc();

      redirect_i = 1'b1; redirect_pc_i = 32'd88;
      cyc();
      redirect_i = 1'b0;
      chk_bubble("redirect88", 32'd88, 1'b0);
      push(32'h1000_0058, 32'd88, 32'd92); cyc();
      push(32'h1000_005C, 32'd92, 32'd96); cyc();
      chk("edge_addr", imem_addr_o, 32'd96);
      cyc();
      chk_bubble("oor_halt", 32'd96, 1'b1);
      chk("oor_pc_hold", id_pc_o, 32'd92);

      redirect_i = 1'b1; redirect_pc_i = 32'd0;
      cyc(); cyc();
      redirect_i = 1'b0;
      chk_bubble("halted_ignores", 32'd96, 1'b1);

      reset = 1'b1; cyc();
      chk_bubble("reset2", 32'd0, 1'b0);
      reset = 1'b0; cyc();
      push(32'h1000_0000, 32'd0, 32'd4);  cyc();
      push(32'h1000_0004, 32'd4, 32'd8);  cyc();
      push(32'h1000_0008, 32'd8, 32'd12); cyc();
      halt_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'd40;
      cyc();
      halt_i = 1'b0; redirect_i = 1'b0;
      chk_bubble("halt_vs_redirect", 32'd12, 1'b1);
      cyc();
      chk("halt_pc_frozen", imem_addr_o, 32'd12);

      reset = 1'b1; cyc();
      chk_bubble("reset3", 32'd0, 1'b0);
      reset = 1'b0; cyc();

      // 5 fetches, 2 stall cycles, 1 redirect.
      push(32'h1000_0000, 32'd0, 32'd4);  cyc();
      push(32'h1000_0004, 32'd4, 32'd8);  cyc();
      push(32'h1000_0008, 32'd8, 32'd12); cyc();
      stall_i = 1'b1;
      push(32'h1000_0008, 32'd8, 32'd12); cyc();
      push(32'h1000_0008, 32'd8, 32'd12); cyc();
      stall_i = 1'b0;
      redirect_i = 1'b1; redirect_pc_i = 32'd40;
      cyc();
      redirect_i = 1'b0;
      push(32'h1000_0028, 32'd40, 32'd44); cyc();
      push(32'h1000_002C, 32'd44, 32'd48); cyc();
      chk("final_addr", imem_addr_o, 32'd48);
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_cnt", fetch_cnt_o, 32'd5);
      chk("stall_cnt", stall_cnt_o, 32'd2);
      chk("flush_cnt", flush_cnt_o, 32'd1);
`endif

      halt_i = 1'b1; cyc(); halt_i = 1'b0;
      @(negedge clk); #1;
      done = 1'b1;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
